// File: rtl/iobus_pkg.sv
// Shared IOBUS definitions: peripheral addresses, UART transmitter state type
// and the bit layout of the UART status word.
package iobus_pkg;

  // Peripheral addresses on the MCU IOBUS
  localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
  localparam logic [31:0] LEDS_AD      = 32'h1108_0000;
  localparam logic [31:0] SSEG_AD      = 32'h110C_0000;
  localparam logic [31:0] CLKCNT_AD    = 32'h1110_0000;
  localparam logic [31:0] UART_DATA_AD = 32'h1180_0000;
  localparam logic [31:0] UART_STAT_AD = 32'h1180_0004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // UART status word layout
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_EMPTY_BIT = 3;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; pops of an empty FIFO are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; push+pop together leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter with byte FIFO and readable status word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (line low) for DIV cycles
// DATA  | data bits LSB first, DIV cycles each, bit_idx selects 0..7
// STOP  | stop bit (line high); chains straight into START if data waits
module iobus_uart_tx
  import iobus_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] DATA_AD    = UART_DATA_AD,
  parameter logic [31:0] STAT_AD    = UART_STAT_AD
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(DIV - 1);

  uart_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic              wr_data_hit, wr_stat_hit, push_ok;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [FCNT_W-1:0] fifo_count;
  logic              bit_end;
  logic              unused_iobus_out;

  assign wr_data_hit = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
  assign wr_stat_hit = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
  // A full FIFO still takes the byte when the FSM drains one in the same cycle
  assign push_ok     = wr_data_hit && (!fifo_full || fifo_pop);
  assign bit_end     = (baud_q == '0);
  assign unused_iobus_out = ^IOBUS_OUT[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   (IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencing: baud down-counter reloads at each bit boundary
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = BIT_RELOAD;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          baud_d    = BIT_RELOAD;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = BIT_RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = BIT_RELOAD;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // TX is registered from the next state so the line is glitch-free
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky overflow flag: set on a dropped byte, cleared by status write bit 2
  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat_hit && IOBUS_OUT[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (wr_data_hit && !push_ok)                ovf_d = 1'b1;
  end

  // Transmitter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  // Status read port, zero unless the status address is presented
  always_comb begin
    RD_DATA = '0;
    if (IOBUS_ADDR == STAT_AD) begin
      RD_DATA[STAT_BUSY_BIT]            = (state_q != IDLE);
      RD_DATA[STAT_FULL_BIT]            = fifo_full;
      RD_DATA[STAT_OVF_BIT]             = ovf_q;
      RD_DATA[STAT_EMPTY_BIT]           = fifo_empty;
      RD_DATA[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Bench for iobus_uart_tx with DIV=10. A queue-based line model predicts TX and
// the status word every cycle; directed sections add hand-computed checks.
module tb_iobus_uart_tx;

  localparam int          DIV     = 10;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] DATA_AD = 32'h1180_0000;
  localparam logic [31:0] STAT_AD = 32'h1180_0004;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = STAT_AD;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        TX;

  int tests = 0;
  int fails = 0;

  iobus_uart_tx #(
    .CLK_HZ     (10),
    .BAUD       (1),
    .FIFO_DEPTH (DEPTH),
    .DATA_AD    (DATA_AD),
    .STAT_AD    (STAT_AD)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .TX         (TX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: byte queue for the FIFO, bit-per-cycle queue for the line
  logic [7:0] mq[$];
  bit         tl[$];
  bit         movf = 1'b0;
  bit         mvalid = 1'b0;
  bit         m_pop;
  logic [7:0] m_byte;

  always @(posedge CLK) begin
    if (RESET) begin
      mq.delete();
      tl.delete();
      movf   = 1'b0;
      mvalid = 1'b1;
    end else begin
      m_pop = (mq.size() != 0) && (tl.size() <= 1);
      if (tl.size() != 0) void'(tl.pop_front());
      if (m_pop) begin
        m_byte = mq.pop_front();
        for (int r = 0; r < DIV; r++) tl.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int r = 0; r < DIV; r++) tl.push_back(m_byte[i]);
        for (int r = 0; r < DIV; r++) tl.push_back(1'b1);
      end
      if (IOBUS_WR && IOBUS_ADDR == DATA_AD) begin
        if (mq.size() < DEPTH) mq.push_back(IOBUS_OUT[7:0]);
        else                   movf = 1'b1;
      end
      if (IOBUS_WR && IOBUS_ADDR == STAT_AD && IOBUS_OUT[2]) movf = 1'b0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    logic [31:0] r;
    r = '0;
    if (addr == STAT_AD) begin
      r[0]    = (tl.size() != 0);
      r[1]    = (mq.size() == DEPTH);
      r[2]    = movf;
      r[3]    = (mq.size() == 0);
      r[15:8] = 8'(mq.size());
    end
    return r;
  endfunction

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge CLK) begin
    if (mvalid) begin
      chk("model_tx", TX, (tl.size() != 0) ? tl[0] : 1'b1);
      chk("model_rd_data", RD_DATA, exp_rd(IOBUS_ADDR));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = STAT_AD;
    IOBUS_OUT  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame_55;
    int         n;
    int         lows;
    logic       tx100, tx101;

    // Reset
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk("reset_tx", TX, 1);
    chk("reset_stat", RD_DATA, 32'h0000_0008);

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop
    frame_55 = 10'b10_1010_1010;
    wr(DATA_AD, 32'h55);
    #1;
    chk("sb_pre_tx", TX, 1);
    chk("sb_queued", RD_DATA, 32'h0000_0100);
    for (int j = 0; j < 100; j++) begin
      tick();
      #1;
      chk("sb_tx", TX, frame_55[j/10]);
      chk("sb_busy", RD_DATA[0], 1);
    end
    tick();
    #1;
    chk("sb_done", RD_DATA, 32'h0000_0008);

    // Back-to-back bytes: 200 busy cycles, no idle gap between frames
    wr(DATA_AD, 32'hA3);
    wr(DATA_AD, 32'h0F);
    #1;
    n = 0;
    tx100 = 1'bx;
    tx101 = 1'bx;
    while (RD_DATA[0] === 1'b1 && n < 400) begin
      n++;
      if (n == 100) tx100 = TX;
      if (n == 101) tx101 = TX;
      tick();
      #1;
    end
    chk("b2b_busy_cycles", n, 200);
    chk("b2b_first_stop", tx100, 1);
    chk("b2b_second_start", tx101, 0);

    // Overflow: ten writes into depth 8, one popped immediately, one dropped
    for (int i = 0; i < 10; i++) wr(DATA_AD, 32'h30 + i);
    #1;
    chk("ovf_stat", RD_DATA, 32'h0000_0807);
    wr(STAT_AD, 32'hFB);
    #1;
    chk("ovf_keep", RD_DATA, 32'h0000_0807);
    wr(STAT_AD, 32'h4);
    #1;
    chk("ovf_clear", RD_DATA, 32'h0000_0803);
    n = 0;
    while (RD_DATA !== 32'h8 && n < 1200) begin
      tick();
      #1;
      n++;
    end
    chk("ovf_drain_stat", RD_DATA, 32'h0000_0008);
    chk("ovf_drain_cycles", n, 890);

    // Reset during data bit 3 of 0xC5 with a second byte queued
    wr(DATA_AD, 32'hC5);
    wr(DATA_AD, 32'h3A);
    repeat (44) tick();
    #1;
    chk("rst_mid_bit3", TX, 0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_mid_tx", TX, 1);
    chk("rst_mid_stat", RD_DATA, 32'h0000_0008);
    lows = 0;
    repeat (300) begin
      tick();
      #1;
      if (TX !== 1'b1) lows++;
    end
    chk("rst_mid_quiet", lows, 0);

    // Address decode
    wr(32'h1108_0000, 32'hFF);
    wr(32'h1180_0008, 32'hAA);
    #1;
    chk("dec_no_push", RD_DATA, 32'h0000_0008);
    IOBUS_ADDR = 32'h1108_0000;
    tick();
    #1;
    chk("dec_rd_leds", RD_DATA, 0);
    IOBUS_ADDR = 32'h1180_0008;
    tick();
    #1;
    chk("dec_rd_other", RD_DATA, 0);
    IOBUS_ADDR = DATA_AD;
    tick();
    #1;
    chk("dec_rd_data_ad", RD_DATA, 0);
    IOBUS_ADDR = STAT_AD;
    repeat (20) tick();
    #1;
    chk("dec_idle_tx", TX, 1);
    chk("dec_idle_stat", RD_DATA, 32'h0000_0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the MCU IOBUS as a write target with a readable status word.
- The MCU writes bytes to a data address. Bytes are queued in a small FIFO and serialised 8N1, LSB first, on TX.
- Sits in the top-level wrapper beside the LEDS/SSEG output registers. It is clocked by the 50 MHz MCU clock.
- Its RD_DATA output is ORed into the wrapper's IOBUS_IN read mux.

Parameters:
- CLK_HZ, 50000000, MCU clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- FIFO_DEPTH, 8, number of byte entries in the FIFO; must be a power of 2 and at least 2.
- DATA_AD, 32'h11800000, write-only data port address.
- STAT_AD, 32'h11800004, status/control port address.

Ports:
- CLK  in  1  MCU clock (sclk domain).
- RESET  in  1  synchronous, active-high reset.
- IOBUS_ADDR  in  32  IOBUS address from the MCU.
- IOBUS_OUT  in  32  IOBUS write data from the MCU.
- IOBUS_WR  in  1  IOBUS write strobe; one-cycle qualifier.
- RD_DATA  out  32  status read data; zero unless IOBUS_ADDR==STAT_AD.
- TX  out  1  serial line; idles high.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET, sampled at the posedge of CLK.
- Reset values: TX=1, FIFO empty (count=0), overflow=0, FSM=IDLE, baud and bit counters =0.
- Reset mid-frame aborts the frame. TX is high from the cycle after the reset edge.
- Baud divider: DIV = CLK_HZ/BAUD, integer-truncated (434 at the defaults). Every TX bit lasts exactly DIV cycles.
- Push: when IOBUS_WR=1 and IOBUS_ADDR==DATA_AD, IOBUS_OUT[7:0] is pushed and count increments at that edge.
- Push accept rule: accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
- Rejected push: the data is dropped and the sticky overflow flag is set.
- Overflow clear: a write to STAT_AD with IOBUS_OUT[2]=1 clears overflow. Other STAT_AD bits are ignored on write.
- Writes to any other address are ignored.
- RD_DATA (combinational) when IOBUS_ADDR==STAT_AD:
  - [0] busy (FSM!=IDLE)
  - [1] full (count==FIFO_DEPTH)
  - [2] overflow
  - [3] empty
  - [15:8] count, zero-extended
  - all other bits 0
- RD_DATA is 0 for any other address.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and load the baud counter.
  - START: TX=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for DIV cycles, then shift right. After bit index 7 completes, go to STOP.
  - STOP: TX=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a push at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. TX falls after edge k+1.
- Frame length is 10*DIV cycles.
- Simultaneous push and pop update count by net 0 and preserve data order.
- Write pointer and read pointer wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).

Decomposition:
- Shared package iobus_pkg:
  - address constants UART_DATA_AD and UART_STAT_AD, alongside the existing SWITCHES/LEDS/SSEG/CLKCNT addresses
  - uart_tx_state_t enum {IDLE, START, DATA, STOP}
  - status bit-index localparams
- One sub-module, sync_fifo, with parameters WIDTH and DEPTH and ports push/pop/din/dout/count/full/empty. It is reusable for a later RX block.
- Baud counter and FSM stay in iobus_uart_tx.

Test Plan:
- Bench setup: CLK_HZ=10, BAUD=1, so DIV=10.
- Reset: assert RESET 2 cycles -> TX=1; RD_DATA at STAT_AD = 0x0000_0008 (empty only).
- Single byte: write 0x55 to DATA_AD -> TX low from cycle k+1 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high 10 cycles. Busy=1 throughout, then 0.
- Back-to-back: write 0xA3 and 0x0F in consecutive cycles -> second start bit begins the cycle after the first stop bit ends. No idle gap; total 200 cycles busy.
- Overflow: write 10 bytes in consecutive cycles (depth 8) -> 9 bytes are transmitted (one is popped immediately) and 1 is dropped. Status overflow=1 and full=1 observed after the 10th write. Writing 0x4 to STAT_AD -> overflow=0.
- Reset mid-frame: assert RESET during DATA bit 3 -> TX=1 next cycle. Count=0 and no further frame is emitted.
- Address decode: writes to 0x11080000 and 0x11800008 -> no push; RD_DATA=0 for non-STAT_AD addresses.
